// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the switch-ALU operator sequencer.
package alu_ctrl_pkg;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned SEL_W       = 4;
  localparam int unsigned NUM_OPS_DEF = 13;

  typedef enum logic [2:0] {
    LOAD_A = 3'd0,
    LOAD_B = 3'd1,
    SEL_OP = 3'd2,
    EXEC   = 3'd3,
    SHOW   = 3'd4
  } state_t;

  localparam logic [SEL_W-1:0] OP_ADD  = 4'd0;
  localparam logic [SEL_W-1:0] OP_SUB  = 4'd1;
  localparam logic [SEL_W-1:0] OP_SHL  = 4'd2;
  localparam logic [SEL_W-1:0] OP_SHR  = 4'd3;
  localparam logic [SEL_W-1:0] OP_CMP  = 4'd4;
  localparam logic [SEL_W-1:0] OP_AND  = 4'd5;
  localparam logic [SEL_W-1:0] OP_OR   = 4'd6;
  localparam logic [SEL_W-1:0] OP_XOR  = 4'd7;
  localparam logic [SEL_W-1:0] OP_NAND = 4'd8;
  localparam logic [SEL_W-1:0] OP_NOR  = 4'd9;
  localparam logic [SEL_W-1:0] OP_XNOR = 4'd10;
  localparam logic [SEL_W-1:0] OP_INV  = 4'd11;
  localparam logic [SEL_W-1:0] OP_NEG  = 4'd12;

  function automatic logic is_valid_op(input logic [SEL_W-1:0] sel, input int unsigned num_ops);
    return 32'(sel) < num_ops;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Synchronises a raw bouncy button, accepts a level after DEBOUNCE_CYCLES
// stable cycles and emits a one-cycle pulse on each accepted press.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic press_p
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;

  // Counter runs only while the synchronised input disagrees with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b00;
      level_q <= 1'b0;
      level_d <= 1'b0;
      cnt_q   <= '0;
      press_p <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_raw};
      level_d <= level_q;
      press_p <= level_q & ~level_d;
      if (sync_q[1] == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        cnt_q   <= '0;
        level_q <= sync_q[1];
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// One-button operator sequencer for the 8-bit switch ALU: load A, load B,
// select op, execute, show. Optional ALU_CHAIN_EN feeds the result back as A.
module alu_op_sequencer
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned NUM_OPS         = NUM_OPS_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_step,
  input  logic       btn_clr,
  input  logic [7:0] sw_data,
  input  logic [3:0] sw_sel,
  input  logic [7:0] alu_result,
  output logic [7:0] op_a,
  output logic [7:0] op_b,
  output logic [3:0] op_sel,
  output logic [7:0] result,
  output logic       result_valid,
  output logic       op_err,
  output logic [2:0] phase
);

  logic step_p;
  logic clr_p;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_step),
    .press_p (step_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clr_db (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_clr),
    .press_p (clr_p)
  );

  state_t     state_q, state_n;
  logic [7:0] op_a_n, op_b_n, result_n;
  logic [3:0] op_sel_n;
  logic       op_err_n;
  logic       result_valid_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= LOAD_A;
      op_a         <= '0;
      op_b         <= '0;
      op_sel       <= '0;
      result       <= '0;
      op_err       <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      state_q      <= state_n;
      op_a         <= op_a_n;
      op_b         <= op_b_n;
      op_sel       <= op_sel_n;
      result       <= result_n;
      op_err       <= op_err_n;
      result_valid <= result_valid_n;
    end
  end

  // Next state and register updates; abort has priority over step.
  always_comb begin
    state_n  = state_q;
    op_a_n   = op_a;
    op_b_n   = op_b;
    op_sel_n = op_sel;
    result_n = result;
    op_err_n = op_err;
    if (clr_p) begin
      state_n  = LOAD_A;
      op_a_n   = '0;
      op_b_n   = '0;
      op_sel_n = '0;
      result_n = '0;
      op_err_n = 1'b0;
    end else begin
      unique case (state_q)
        LOAD_A: if (step_p) begin
          op_a_n  = sw_data;
          state_n = LOAD_B;
        end
        LOAD_B: if (step_p) begin
          op_b_n  = sw_data;
          state_n = SEL_OP;
        end
        SEL_OP: if (step_p) begin
          op_sel_n = sw_sel;
          op_err_n = ~is_valid_op(sw_sel, NUM_OPS);
          state_n  = EXEC;
        end
        EXEC: begin
          result_n = op_err ? 8'h00 : alu_result;
          state_n  = SHOW;
        end
        SHOW: if (step_p) begin
          op_err_n = 1'b0;
`ifdef ALU_CHAIN_EN
          op_a_n   = result;
          state_n  = LOAD_B;
`else
          state_n  = LOAD_A;
`endif
        end
        default: state_n = LOAD_A;
      endcase
    end
  end

  assign result_valid_n = (state_n == SHOW);
  assign phase          = state_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a short debounce and a behavioural ALU.
module tb_alu_op_sequencer;
  import alu_ctrl_pkg::*;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = DB + 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_step = 1'b0;
  logic       btn_clr = 1'b0;
  logic [7:0] sw_data = '0;
  logic [3:0] sw_sel = '0;
  logic [7:0] alu_result;
  logic [7:0] op_a, op_b, result;
  logic [3:0] op_sel;
  logic       result_valid, op_err;
  logic [2:0] phase;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.DEBOUNCE_CYCLES(DB), .NUM_OPS(13)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_step     (btn_step),
    .btn_clr      (btn_clr),
    .sw_data      (sw_data),
    .sw_sel       (sw_sel),
    .alu_result   (alu_result),
    .op_a         (op_a),
    .op_b         (op_b),
    .op_sel       (op_sel),
    .result       (result),
    .result_valid (result_valid),
    .op_err       (op_err),
    .phase        (phase)
  );

  // Behavioural ALU op mux
  always_comb begin
    case (op_sel)
      OP_ADD:  alu_result = op_a + op_b;
      OP_SUB:  alu_result = op_a - op_b;
      OP_SHL:  alu_result = op_a << 1;
      OP_SHR:  alu_result = op_a >> 1;
      OP_CMP:  alu_result = (op_a == op_b) ? 8'h00 : ((op_a > op_b) ? 8'h01 : 8'hFF);
      OP_AND:  alu_result = op_a & op_b;
      OP_OR:   alu_result = op_a | op_b;
      OP_XOR:  alu_result = op_a ^ op_b;
      OP_NAND: alu_result = ~(op_a & op_b);
      OP_NOR:  alu_result = ~(op_a | op_b);
      OP_XNOR: alu_result = ~(op_a ^ op_b);
      OP_INV:  alu_result = ~op_a;
      OP_NEG:  alu_result = 8'h00 - op_a;
      default: alu_result = 8'hA5;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press_step(input logic [7:0] data, input logic [3:0] sel);
    sw_data  = data;
    sw_sel   = sel;
    btn_step = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_step = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic press_clr();
    btn_clr = 1'b1;
    repeat (HOLD) @(negedge clk);
    btn_clr = 1'b0;
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic wait_phase(input string tag, input logic [2:0] p, input int budget);
    for (int i = 0; i < budget && phase != p; i++) @(negedge clk);
    check_eq(tag, 32'(phase), 32'(p));
  endtask

  task automatic check_regs(input string tag, input logic [7:0] a, input logic [7:0] b,
                            input logic [3:0] s, input logic [7:0] r, input logic err,
                            input logic rv, input logic [2:0] p);
    check_eq({tag, ".op_a"},   32'(op_a),         32'(a));
    check_eq({tag, ".op_b"},   32'(op_b),         32'(b));
    check_eq({tag, ".op_sel"}, 32'(op_sel),       32'(s));
    check_eq({tag, ".result"}, 32'(result),       32'(r));
    check_eq({tag, ".op_err"}, 32'(op_err),       32'(err));
    check_eq({tag, ".rvalid"}, 32'(result_valid), 32'(rv));
    check_eq({tag, ".phase"},  32'(phase),        32'(p));
  endtask

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    check_regs("reset", 8'h00, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Full pass: 3C + 05 = 41
    press_step(8'h3C, 4'h0);
    check_regs("t1_a", 8'h3C, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 3'd1);
    press_step(8'h05, 4'h0);
    check_regs("t1_b", 8'h3C, 8'h05, 4'h0, 8'h00, 1'b0, 1'b0, 3'd2);
    sw_sel   = 4'h0;
    btn_step = 1'b1;
    wait_phase("t1_exec", 3'd3, 30);
    check_eq("t1_exec_rv", 32'(result_valid), 32'h0);
    @(negedge clk);
    check_regs("t1_show", 8'h3C, 8'h05, 4'h0, 8'h41, 1'b0, 1'b1, 3'd4);
    btn_step = 1'b0;
    repeat (HOLD) @(negedge clk);
    press_step(8'hFF, 4'h0);
    check_regs("t1_done", 8'h3C, 8'h05, 4'h0, 8'h41, 1'b0, 1'b0, 3'd0);

    // Abort at SEL_OP with step pressed in the same cycle
    press_step(8'h21, 4'h0);
    press_step(8'h22, 4'h0);
    check_eq("t4_pre", 32'(phase), 32'd2);
    btn_step = 1'b1;
    btn_clr  = 1'b1;
    repeat (HOLD) @(negedge clk);
    check_regs("t4_abort", 8'h00, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);
    btn_step = 1'b0;
    btn_clr  = 1'b0;
    repeat (HOLD) @(negedge clk);
    check_eq("t4_hold", 32'(phase), 32'd0);

    // Bounce: no advance while toggling, then one advance 8 edges after settling
    sw_data = 8'hAA;
    for (int i = 0; i < 20; i++) begin
      btn_step = ((i / 2) % 2) == 0;
      @(negedge clk);
    end
    check_eq("t2_bounce", 32'(phase), 32'd0);
    btn_step = 1'b1;
    lat = 0;
    while (lat < 40 && phase == 3'd0) begin
      @(posedge clk);
      lat++;
      #1;
    end
    // debounce pulse latency DB+3, plus one edge for the state register
    check_eq("t2_latency", 32'(lat), 32'(DB + 4));
    check_eq("t2_op_a", 32'(op_a), 32'h0000_00AA);
    repeat (20) @(negedge clk);
    check_eq("t2_single", 32'(phase), 32'd1);
    btn_step = 1'b0;
    repeat (HOLD) @(negedge clk);

    // Invalid op 4'hE
    press_step(8'h11, 4'h0);
    press_step(8'h00, 4'hE);
    check_regs("t3_show", 8'hAA, 8'h11, 4'hE, 8'h00, 1'b1, 1'b1, 3'd4);
    press_step(8'h00, 4'h0);
    check_eq("t3_err_clr", 32'(op_err), 32'h0);
    check_eq("t3_rv_clr", 32'(result_valid), 32'h0);
`ifdef ALU_CHAIN_EN
    check_eq("t3_phase", 32'(phase), 32'd1);
`else
    check_eq("t3_phase", 32'(phase), 32'd0);
`endif
    press_clr();
    check_eq("t3_clr", 32'(phase), 32'd0);

    // Async reset during EXEC
    press_step(8'h77, 4'h0);
    press_step(8'h66, 4'h0);
    sw_sel   = OP_XOR;
    btn_step = 1'b1;
    wait_phase("t5_exec", 3'd3, 30);
    check_eq("t5_pre_a", 32'(op_a), 32'h0000_0077);
    rst_n    = 1'b0;
    btn_step = 1'b0;
    #1;
    check_regs("t5_rst", 8'h00, 8'h00, 4'h0, 8'h00, 1'b0, 1'b0, 3'd0);
    rst_n = 1'b1;
    repeat (HOLD) @(negedge clk);
    check_eq("t5_after", 32'(phase), 32'd0);

    // SUB 10 - 01 = 0F, then chained (or not) second step
    press_step(8'h10, 4'h0);
    press_step(8'h01, 4'h0);
    press_step(8'h00, OP_SUB);
    check_regs("t6_show", 8'h10, 8'h01, OP_SUB, 8'h0F, 1'b0, 1'b1, 3'd4);
    press_step(8'h55, 4'h0);
`ifdef ALU_CHAIN_EN
    check_regs("t6_chain", 8'h0F, 8'h01, OP_SUB, 8'h0F, 1'b0, 1'b0, 3'd1);
    press_step(8'h0F, 4'h0);
    press_step(8'h00, OP_SUB);
    check_regs("t6_chain2", 8'h0F, 8'h0F, OP_SUB, 8'h00, 1'b0, 1'b1, 3'd4);
`else
    check_regs("t6_nochain", 8'h10, 8'h01, OP_SUB, 8'h0F, 1'b0, 1'b0, 3'd0);
    press_step(8'hC3, 4'h0);
    press_step(8'h0F, 4'h0);
    press_step(8'h00, OP_NAND);
    check_regs("t6_nand", 8'hC3, 8'h0F, OP_NAND, 8'hFC, 1'b0, 1'b1, 3'd4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
